ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit for the SISC processor. Holds the program counter and instruction register, and runs a request/acknowledge handshake with instruction memory. It supplies `opcode`, `mm` and the full instruction word to `ctrl`. It is the producer end of the control unit's instruction inputs: `ctrl` commands fetches and branches; `ifetch` performs them and reports completion.

## Interface
Parameters:
- `AW`, 16: program counter / instruction address width.
- `TIMEOUT`, 16: number of consecutive request cycles without acknowledge before a fetch fault.

Ports:
- `clk`, in, 1: system clock, positive edge active.
- `rst_f`, in, 1: reset; asynchronous and active-low.
- `fetch`, in, 1: one-cycle command from `ctrl` to fetch the instruction at PC.
- `br_take`, in, 1: apply a branch to PC.
- `br_rel`, in, 1: branch is relative (1: PC+`br_off`) or absolute (0: `br_off`).
- `br_off`, in, AW: branch target or offset (instr[15:0]).
- `im_req`, out, 1: instruction memory request.
- `im_addr`, out, AW: instruction memory address; equals `pc`.
- `im_ack`, in, 1: memory acknowledge; `im_data` is valid in the same cycle.
- `im_data`, in, 32: instruction word from memory.
- `instr`, out, 32: instruction register.
- `opcode`, out, 4: instr[31:28].
- `mm`, out, 4: instr[27:24].
- `pc`, out, AW: program counter.
- `ir_valid`, out, 1: instruction register holds a completed fetch.
- `busy`, out, 1: fetch in progress (state REQ).
- `fault`, out, 1: sticky fetch timeout flag.

## Operation
- States: IDLE, REQ. Encoding is 1 bit and lives in the package.
- Reset (`rst_f` low, any time, including mid-fetch) sets:
  - state to IDLE;
  - `pc`, `instr` and the timeout counter to 0;
  - `im_req`, `ir_valid`, `busy` and `fault` to 0.
- IDLE, `br_take`=1: PC is loaded with `br_rel ? pc+br_off : br_off`. Arithmetic is modulo 2^AW; wrap-around is silent.
- IDLE, `fetch`=1: go to REQ, clear `ir_valid`, clear the timeout counter.
- IDLE, `fetch` and `br_take` in the same cycle: the branch is applied and the fetch is issued from the new PC.
- REQ: `im_req`=1 and `im_addr`=`pc`; both are held stable until the cycle ends in acknowledge or timeout.
- REQ, `im_ack`=1 at the clock edge:
  - `instr`<=`im_data`;
  - `pc`<=`pc`+1, wrapping to 0 after all ones;
  - `ir_valid`<=1;
  - go to IDLE.
- REQ, no ack: the counter increments. When TIMEOUT request cycles have elapsed without ack:
  - `instr`<=0 (NOOP);
  - `pc` is unchanged;
  - `ir_valid`<=1 and `fault`<=1;
  - go to IDLE.
- Ack and timeout on the same edge: the ack wins and `fault` is not set.
- `fetch` and `br_take` are ignored in REQ. `ctrl` never issues them there.
- `fault` stays set until reset. Later fetches proceed normally.

## Timing
- `fetch` sampled high at edge N:
  - `im_req` is high from cycle N+1.
  - With ack in cycle N+1, `instr` updates at edge N+1 and `ir_valid`=1 from cycle N+2.
  - The next `fetch` is accepted at edge N+2.
- Minimum fetch latency is 2 cycles. Throughput is one fetch per 2 cycles.
- `im_ack` may be combinational from `im_req`.
- `opcode` and `mm` are pure slices of `instr` and change only on the capture edge.
- `busy` equals `im_req`. Both are registered outputs with no combinational path from inputs.
- A branch in IDLE is visible on `pc` the cycle after it is sampled.

## Structure
- Shared package `sisc_pkg` holds:
  - the opcode constants (NOOP=0 … ALU_OP=8, HLT=15);
  - the state encoding for IDLE and REQ;
  - the default TIMEOUT.
- One sub-module, `pc_unit`, holds the PC register, the +1 incrementer and the branch target adder/mux. Its controls are `inc`, `load` and `rel`.
- The handshake FSM, timeout counter and IR stay in `ifetch`.

## Test plan
- Reset then `fetch` with a 0-wait ack returning 0x1A200003:
  - `im_addr`=0 during REQ;
  - `opcode`=1 and `mm`=0xA;
  - `pc`=1 and `ir_valid`=1 two cycles after `fetch`.
- Ack delayed 5 cycles:
  - `im_req` and `im_addr` are stable for all 5 cycles;
  - capture happens on the ack edge;
  - `busy` falls in the next cycle.
- `pc`=0x0010, `br_take`=1, `br_rel`=1, `br_off`=0xFFFE: `pc`=0x000E. Then absolute `br_off`=0x0040 gives `pc`=0x0040. PC 0xFFFF plus a fetch wraps to 0x0000.
- `fetch` and an absolute branch to 0x0100 in the same cycle: the first `im_addr` is 0x0100 and `pc`=0x0101 after ack.
- No ack with TIMEOUT=16:
  - after 16 REQ cycles, `instr`=0, `fault`=1, `ir_valid`=1, `pc` unchanged.
  - A second run with ack in exactly the 16th cycle gives a normal capture and `fault`=0.
- `rst_f` pulled low mid-REQ: all outputs go to 0 immediately, without waiting for `clk`. After release, the FSM is in IDLE and ignores a late `im_ack`.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared opcodes, fetch state encoding and default fetch timeout.
package sisc_pkg;
  typedef enum logic [3:0] {
    NOOP   = 4'd0,
    ALU_OP = 4'd8,
    HLT    = 4'd15
  } opcode_e;
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter with +1 increment and absolute/relative branch load.
module pc_unit #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          inc,
  input  logic          load,
  input  logic          rel,
  input  logic [AW-1:0] off,
  output logic [AW-1:0] pc
);
  logic [AW-1:0] pc_d, pc_q;
  always_comb pc_d = load ? (rel ? pc_q + off : off) : inc ? pc_q + AW'(1) : pc_q;
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) pc_q <= '0;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit; request/ack handshake with timeout, IR and PC.
module ifetch
  import sisc_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch,
  input  logic          br_take,
  input  logic          br_rel,
  input  logic [AW-1:0] br_off,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [31:0]   im_data,
  output logic [31:0]   instr,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          busy,
  output logic          fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  fetch_state_e  state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [31:0]   instr_d, instr_q;
  logic          ir_valid_d, ir_valid_q, fault_d, fault_q;
  logic          inc, load;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;
    inc        = 1'b0;
    load       = 1'b0;
    if (state_q == IDLE) begin
      load = br_take;
      if (fetch) begin
        state_d    = REQ;
        ir_valid_d = 1'b0;
        cnt_d      = '0;
      end
    end else if (im_ack) begin
      instr_d    = im_data;
      inc        = 1'b1;
      ir_valid_d = 1'b1;
      state_d    = IDLE;
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      // Timeout delivers a NOOP so ctrl can keep stepping.
      instr_d    = {NOOP, 28'd0};
      ir_valid_d = 1'b1;
      fault_d    = 1'b1;
      state_d    = IDLE;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      instr_q    <= '0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
    end
  pc_unit #(.AW(AW)) u_pc (
    .clk  (clk),
    .rst_f(rst_f),
    .inc  (inc),
    .load (load),
    .rel  (br_rel),
    .off  (br_off),
    .pc   (pc)
  );
  assign im_req   = state_q == REQ;
  assign busy     = im_req;
  assign im_addr  = pc;
  assign instr    = instr_q;
  assign opcode   = instr_q[31:28];
  assign mm       = instr_q[27:24];
  assign ir_valid = ir_valid_q;
  assign fault    = fault_q;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed vector table plus handwritten multi-cycle sequences for ifetch.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        fetch = 1'b0, br_take = 1'b0, br_rel = 1'b0, im_ack = 1'b0;
  logic [15:0] br_off = '0;
  logic [31:0] im_data = '0;
  logic        im_req, ir_valid, busy, fault;
  logic [15:0] im_addr, pc;
  logic [31:0] instr;
  logic [3:0]  opcode, mm;
  int checks = 0, errors = 0;

  ifetch #(.AW(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst_f(rst_f), .fetch(fetch), .br_take(br_take), .br_rel(br_rel),
    .br_off(br_off), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_data(im_data), .instr(instr), .opcode(opcode), .mm(mm), .pc(pc),
    .ir_valid(ir_valid), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f, bt, br;
    logic [15:0] off;
    logic        ack;
    logic [31:0] data;
    logic [15:0] pc;
    logic        req, irv;
    logic [31:0] instr;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic e_req,
                         input logic e_irv, input logic [31:0] e_instr, input logic e_fault);
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".im_addr"}, 32'(im_addr), 32'(e_pc));
    chk({tag, ".im_req"}, 32'(im_req), 32'(e_req));
    chk({tag, ".busy"}, 32'(busy), 32'(e_req));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_irv));
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".opcode"}, 32'(opcode), 32'(e_instr[31:28]));
    chk({tag, ".mm"}, 32'(mm), 32'(e_instr[27:24]));
    chk({tag, ".fault"}, 32'(fault), 32'(e_fault));
  endtask

  task automatic drive(input logic f, input logic bt, input logic br, input logic [15:0] off,
                       input logic ack, input logic [31:0] data);
    fetch = f; br_take = bt; br_rel = br; br_off = off; im_ack = ack; im_data = data;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0);
    rst_f = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_f = 1'b1;
    #1;
  endtask

  initial begin
    //             f  bt br off      ack data          pc       req irv instr
    vt.push_back('{1, 0, 0, 16'h0000, 0, 32'h0,        16'h0000, 1, 0, 32'h0});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 32'h1A200003, 16'h0001, 0, 1, 32'h1A200003});
    vt.push_back('{0, 1, 0, 16'h0010, 0, 32'h0,        16'h0010, 0, 1, 32'h1A200003});
    vt.push_back('{0, 1, 1, 16'hFFFE, 0, 32'h0,        16'h000E, 0, 1, 32'h1A200003});
    vt.push_back('{0, 1, 0, 16'h0040, 0, 32'h0,        16'h0040, 0, 1, 32'h1A200003});
    vt.push_back('{0, 1, 0, 16'hFFFF, 0, 32'h0,        16'hFFFF, 0, 1, 32'h1A200003});
    vt.push_back('{1, 0, 0, 16'h0000, 0, 32'h0,        16'hFFFF, 1, 0, 32'h1A200003});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 32'h80000005, 16'h0000, 0, 1, 32'h80000005});
    vt.push_back('{1, 1, 0, 16'h0100, 0, 32'h0,        16'h0100, 1, 0, 32'h80000005});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 32'hF0000000, 16'h0101, 0, 1, 32'hF0000000});
    vt.push_back('{0, 1, 1, 16'h0002, 0, 32'h0,        16'h0103, 0, 1, 32'hF0000000});
    vt.push_back('{0, 1, 1, 16'h0001, 1, 32'h12345678, 16'h0104, 0, 1, 32'hF0000000});
    vt.push_back('{1, 0, 0, 16'h0000, 0, 32'h0,        16'h0104, 1, 0, 32'hF0000000});
    vt.push_back('{1, 1, 0, 16'h0000, 0, 32'h0,        16'h0104, 1, 0, 32'hF0000000});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 32'h81000009, 16'h0105, 0, 1, 32'h81000009});

    #2;
    chk_all("reset", 16'h0, 0, 0, 32'h0, 0);
    do_reset();
    chk_all("post_reset", 16'h0, 0, 0, 32'h0, 0);

    foreach (vt[i]) begin
      drive(vt[i].f, vt[i].bt, vt[i].br, vt[i].off, vt[i].ack, vt[i].data);
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].req, vt[i].irv, vt[i].instr, 0);
    end

    // Ack delayed: 5 REQ cycles, ack arrives in the 5th.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 16'h0777, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      chk_all($sformatf("wait%0d", c), 16'h0105, 1, 0, 32'h81000009, 0);
      tick();
    end
    chk_all("wait5", 16'h0105, 1, 0, 32'h81000009, 0);
    drive(0, 0, 0, 0, 1, 32'h2B000007);
    tick();
    chk_all("late_ack", 16'h0106, 0, 1, 32'h2B000007, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Timeout: 16 REQ cycles with no ack.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (15) tick();
    chk_all("to_cycle16", 16'h0106, 1, 0, 32'h2B000007, 0);
    tick();
    chk_all("timeout", 16'h0106, 0, 1, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h30000001);
    tick();
    chk_all("after_fault", 16'h0107, 0, 1, 32'h30000001, 1);
    tick();
    chk_all("fault_sticky", 16'h0107, 0, 1, 32'h30000001, 1);

    // Ack in exactly the 16th REQ cycle wins over timeout.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (15) tick();
    drive(0, 0, 0, 0, 1, 32'h8C00BEEF);
    tick();
    chk_all("ack16", 16'h0001, 0, 1, 32'h8C00BEEF, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-REQ, then a late ack must be ignored.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_all("pre_arst", 16'h0001, 1, 0, 32'h8C00BEEF, 0);
    #2 rst_f = 1'b0;
    #1;
    chk_all("arst", 16'h0, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 1, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    rst_f = 1'b1;
    tick();
    chk_all("late_ack_ignored", 16'h0, 0, 0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
